// File: rtl/dma_desc_pkg.sv
// Shared types and constants for the DMA descriptor-table responder.
// Byte-lane merge helper used by every write path into the table.
package dma_desc_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } desc_mem_state_t;

    localparam int DMA_DESC_WORDS      = 8;
    localparam int DMA_DESC_BYTE_LANES = 4;

    function automatic logic [31:0] apply_be(
        input logic [31:0]                    old_word,
        input logic [31:0]                    new_word,
        input logic [DMA_DESC_BYTE_LANES-1:0] be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < DMA_DESC_BYTE_LANES; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dma_desc_mem_arb.sv
// Fixed-priority arbiter for the descriptor-table port: update write > fetch read > host write.
// The host leg exists only when DMA_DESC_MEM_HOST_PORT_EN is defined.
module dma_desc_mem_arb (
    input  logic busy_i,
    input  logic upd_wr_i,
    input  logic fetch_rd_i,
`ifdef DMA_DESC_MEM_HOST_PORT_EN
    input  logic host_wr_i,
    output logic host_wait_o,
    output logic host_gnt_o,
`endif
    output logic upd_wait_o,
    output logic upd_gnt_o,
    output logic fetch_wait_o,
    output logic fetch_gnt_o
);

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        upd_wait_o   = busy_i;
        fetch_wait_o = busy_i | upd_wr_i;
        upd_gnt_o    = upd_wr_i & ~upd_wait_o;
        fetch_gnt_o  = fetch_rd_i & ~fetch_wait_o;
`ifdef DMA_DESC_MEM_HOST_PORT_EN
        host_wait_o  = busy_i | upd_wr_i | fetch_rd_i;
        host_gnt_o   = host_wr_i & ~host_wait_o;
`endif
    end

endmodule

// File: rtl/dma_desc_mem_responder.sv
// Avalon-MM responder holding the scatter-gather descriptor table; serves burst reads and byte-enabled writes.
// Optional software preload port enabled by DMA_DESC_MEM_HOST_PORT_EN.
module dma_desc_mem_responder
    import dma_desc_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_desc_fetch_read_i,
    input  logic [3:0]  dma_desc_fetch_bcount_i,
    input  logic [31:0] dma_desc_fetch_addr_i,
    output logic        dma_desc_fetch_waitrequest_o,
    output logic [31:0] dma_desc_fetch_rddata_o,
    output logic        dma_desc_fetch_readdatavalid_o,
    input  logic        dma_desc_update_wr_i,
    input  logic [31:0] dma_desc_update_data_i,
    input  logic [3:0]  dma_desc_update_be_i,
    input  logic [31:0] dma_desc_update_addr_i,
`ifdef DMA_DESC_MEM_HOST_PORT_EN
    input  logic        host_wr_i,
    input  logic [31:0] host_addr_i,
    input  logic [31:0] host_wr_data_i,
    input  logic [3:0]  host_be_i,
    output logic        host_wait_rq_o,
`endif
    output logic        dma_desc_update_wait_req_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    desc_mem_state_t   state_q, state_d;
    logic [3:0]        beats_left_q, beats_left_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       rddata_q, rddata_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [31:0]       mem_d [DEPTH_WORDS];

    logic              upd_gnt, fetch_gnt;
    logic [IDX_W-1:0]  fetch_idx, upd_idx;
    logic [3:0]        burst_len;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;

    assign fetch_idx = dma_desc_fetch_addr_i[2 +: IDX_W];
    assign upd_idx   = dma_desc_update_addr_i[2 +: IDX_W];
    assign burst_len = (dma_desc_fetch_bcount_i == 4'd0) ? 4'd1 : dma_desc_fetch_bcount_i;

`ifdef DMA_DESC_MEM_HOST_PORT_EN
    logic             host_gnt;
    logic [IDX_W-1:0] host_idx;
    logic             unused_host_addr;

    assign host_idx         = host_addr_i[2 +: IDX_W];
    assign unused_host_addr = ^{host_addr_i[31:2+IDX_W], host_addr_i[1:0]};
`endif

    // Byte offset and bits above the table size are don't-care; addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dma_desc_fetch_addr_i[31:2+IDX_W], dma_desc_fetch_addr_i[1:0],
                                dma_desc_update_addr_i[31:2+IDX_W], dma_desc_update_addr_i[1:0]};

    dma_desc_mem_arb u_arb (
        .busy_i       (state_q == ST_BURST),
        .upd_wr_i     (dma_desc_update_wr_i),
        .fetch_rd_i   (dma_desc_fetch_read_i),
`ifdef DMA_DESC_MEM_HOST_PORT_EN
        .host_wr_i    (host_wr_i),
        .host_wait_o  (host_wait_rq_o),
        .host_gnt_o   (host_gnt),
`endif
        .upd_wait_o   (dma_desc_update_wait_req_o),
        .upd_gnt_o    (upd_gnt),
        .fetch_wait_o (dma_desc_fetch_waitrequest_o),
        .fetch_gnt_o  (fetch_gnt)
    );

    always_comb begin
        wr_en   = upd_gnt;
        wr_idx  = upd_idx;
        wr_data = dma_desc_update_data_i;
        wr_be   = dma_desc_update_be_i;
`ifdef DMA_DESC_MEM_HOST_PORT_EN
        if (host_gnt) begin
            wr_en   = 1'b1;
            wr_idx  = host_idx;
            wr_data = host_wr_data_i;
            wr_be   = host_be_i;
        end
`endif
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_idx] = apply_be(mem_q[wr_idx], wr_data, wr_be);
    end

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        idx_d        = idx_q;
        rvalid_d     = 1'b0;
        rddata_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_gnt) begin
                    rvalid_d = 1'b1;
                    rddata_d = mem_q[fetch_idx];
                    if (burst_len > 4'd1) begin
                        state_d      = ST_BURST;
                        beats_left_d = burst_len - 4'd1;
                        idx_d        = fetch_idx + IDX_W'(1);
                    end
                end
            end
            ST_BURST: begin
                rvalid_d     = 1'b1;
                rddata_d     = mem_q[idx_q];
                idx_d        = idx_q + IDX_W'(1);
                beats_left_d = beats_left_q - 4'd1;
                if (beats_left_q == 4'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            beats_left_q <= '0;
            idx_q        <= '0;
            rvalid_q     <= 1'b0;
            rddata_q     <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            idx_q        <= idx_d;
            rvalid_q     <= rvalid_d;
            rddata_q     <= rddata_d;
        end
    end

    // NOTE: the table is register-based and cleared on reset so every descriptor starts software-owned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dma_desc_fetch_rddata_o        = rddata_q;
    assign dma_desc_fetch_readdatavalid_o = rvalid_q;

endmodule
